// File: rtl/fifo_sync_ctrl_if.sv
// ---------------------------------------------------------------------------
// fifo_sync_ctrl_if
// Groups the request/status signals of the synchronous FIFO controller.
//   master : requester side, drives W_EN / R_EN / CLR_ERR and observes status
//   slave  : controller side, consumes requests and drives pointers, flags,
//            occupancy, acknowledges and sticky error flags
// Signals:
//   W_EN, R_EN, CLR_ERR              requests / error clear
//   W_PTR, R_PTR                     pointers (MSB is the wrap bit)
//   COUNT                            occupancy 0..DEPTH
//   FULL, EMPTY                      registered occupancy flags
//   ALMOST_FULL, ALMOST_EMPTY        registered threshold flags
//   W_ACK, R_ACK                     request accepted this cycle
//   OVERFLOW, UNDERFLOW              sticky error flags
// ---------------------------------------------------------------------------
interface fifo_sync_ctrl_if #(
  parameter int PTR_WIDTH = 5
);
  logic                 W_EN;
  logic                 R_EN;
  logic                 CLR_ERR;
  logic [PTR_WIDTH-1:0] W_PTR;
  logic [PTR_WIDTH-1:0] R_PTR;
  logic [PTR_WIDTH-1:0] COUNT;
  logic                 FULL;
  logic                 EMPTY;
  logic                 ALMOST_FULL;
  logic                 ALMOST_EMPTY;
  logic                 W_ACK;
  logic                 R_ACK;
  logic                 OVERFLOW;
  logic                 UNDERFLOW;

  modport master (
    output W_EN, R_EN, CLR_ERR,
    input  W_PTR, R_PTR, COUNT, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY,
           W_ACK, R_ACK, OVERFLOW, UNDERFLOW
  );

  modport slave (
    input  W_EN, R_EN, CLR_ERR,
    output W_PTR, R_PTR, COUNT, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY,
           W_ACK, R_ACK, OVERFLOW, UNDERFLOW
  );
endinterface

// File: rtl/fifo_sync_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_sync_ctrl
// Pointer/flag controller for a first-word-fall-through synchronous FIFO.
// The storage array lives outside this block: it writes at W_PTR when
// W_EN & !FULL and reads combinationally at R_PTR.
// Ports:
//   CLK   sole clock, rising edge
//   NRST  asynchronous active-low reset
//   bus   fifo_sync_ctrl_if.slave (requests in; pointers, COUNT, flags,
//         acknowledges and sticky error flags out)
// ---------------------------------------------------------------------------
module fifo_sync_ctrl #(
  parameter int DEPTH     = 16,
  parameter int PTR_WIDTH = 5,
  parameter int AF_LEVEL  = DEPTH - 2,
  parameter int AE_LEVEL  = 2
) (
  input  logic             CLK,
  input  logic             NRST,
  fifo_sync_ctrl_if.slave  bus
);

  localparam logic [PTR_WIDTH-1:0] DEPTH_C = PTR_WIDTH'(DEPTH);
  localparam logic [PTR_WIDTH-1:0] AF_C    = PTR_WIDTH'(AF_LEVEL);
  localparam logic [PTR_WIDTH-1:0] AE_C    = PTR_WIDTH'(AE_LEVEL);
  localparam logic [PTR_WIDTH-1:0] ONE_C   = PTR_WIDTH'(1);

  logic [PTR_WIDTH-1:0] wPtr_q, wPtr_d;
  logic [PTR_WIDTH-1:0] rPtr_q, rPtr_d;
  logic [PTR_WIDTH-1:0] count_q, count_d;
  logic                 full_q, full_d;
  logic                 empty_q, empty_d;
  logic                 aFull_q, aFull_d;
  logic                 aEmpty_q, aEmpty_d;
  logic                 ovf_q, ovf_d;
  logic                 udf_q, udf_d;
  logic                 wAck;
  logic                 rAck;

  // Acknowledges depend only on the registered flags, so a read request can
  // never ripple into the write acknowledge (or vice versa).
  assign wAck = bus.W_EN & ~full_q;
  assign rAck = bus.R_EN & ~empty_q;

  // Next-state logic. Flags are derived from the next occupancy so they are
  // registered alongside COUNT and always agree with it. Because COUNT tracks
  // W_PTR - R_PTR, COUNT==DEPTH is the "MSBs differ, low bits equal" case and
  // COUNT==0 is the "pointers equal" case.
  always_comb begin
    wPtr_d  = wPtr_q;
    rPtr_d  = rPtr_q;
    count_d = count_q;
    if (wAck) begin
      wPtr_d = wPtr_q + ONE_C;
    end
    if (rAck) begin
      rPtr_d = rPtr_q + ONE_C;
    end
    case ({wAck, rAck})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase
    full_d   = (count_d == DEPTH_C);
    empty_d  = (count_d == '0);
    aFull_d  = (count_d >= AF_C);
    aEmpty_d = (count_d <= AE_C);
  end

  // Sticky error flags: a clear and a fresh error in the same cycle leave the
  // flag set, so the set is applied last.
  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (bus.CLR_ERR) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (bus.W_EN & full_q) begin
      ovf_d = 1'b1;
    end
    if (bus.R_EN & empty_q) begin
      udf_d = 1'b1;
    end
  end

  // State registers; reset empties the FIFO by zeroing both pointers, which
  // makes whatever the storage array still holds unreachable.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      wPtr_q   <= '0;
      rPtr_q   <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      aFull_q  <= 1'b0;
      aEmpty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wPtr_q   <= wPtr_d;
      rPtr_q   <= rPtr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      aFull_q  <= aFull_d;
      aEmpty_q <= aEmpty_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  assign bus.W_PTR        = wPtr_q;
  assign bus.R_PTR        = rPtr_q;
  assign bus.COUNT        = count_q;
  assign bus.FULL         = full_q;
  assign bus.EMPTY        = empty_q;
  assign bus.ALMOST_FULL  = aFull_q;
  assign bus.ALMOST_EMPTY = aEmpty_q;
  assign bus.W_ACK        = wAck;
  assign bus.R_ACK        = rAck;
  assign bus.OVERFLOW     = ovf_q;
  assign bus.UNDERFLOW    = udf_q;

endmodule

// File: doc/fifo_sync_ctrl.md
FIFO_SYNC_CTRL -- requirements
Module: fifo_sync_ctrl

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16: number of storage entries, a power of two, at least 4.
REQ-002 The block SHALL have parameter PTR_WIDTH, default 5: log2(DEPTH)+1, where the MSB is the wrap bit.
REQ-003 The block SHALL have parameter AF_LEVEL, default DEPTH-2: occupancy at or above which ALMOST_FULL is asserted.
REQ-004 The block SHALL have parameter AE_LEVEL, default 2: occupancy at or below which ALMOST_EMPTY is asserted.
REQ-005 The block SHALL have the following ports; the single clock is CLK and the reset is NRST, asynchronous and active-low:
- CLK  in  1  sole clock; all state updates on the rising edge.
- NRST  in  1  asynchronous active-low reset.
- W_EN  in  1  write request.
- R_EN  in  1  read request.
- CLR_ERR  in  1  synchronous clear of the sticky error flags.
- W_PTR  out  PTR_WIDTH  write pointer; the low PTR_WIDTH-1 bits address the storage array.
- R_PTR  out  PTR_WIDTH  read pointer; same format as W_PTR.
- FULL  out  1  no free entries.
- EMPTY  out  1  no valid entries.
- ALMOST_FULL  out  1  COUNT >= AF_LEVEL.
- ALMOST_EMPTY  out  1  COUNT <= AE_LEVEL.
- COUNT  out  PTR_WIDTH  occupancy, range 0..DEPTH.
- W_ACK  out  1  write accepted this cycle (combinational).
- R_ACK  out  1  read accepted this cycle (combinational).
- OVERFLOW  out  1  sticky: a write was attempted while FULL.
- UNDERFLOW  out  1  sticky: a read was attempted while EMPTY.
REQ-006 W_PTR, R_PTR and FULL SHALL connect directly to the storage array, which writes on W_EN & !FULL and reads combinationally at R_PTR.

Function
REQ-007 The block SHALL compute W_ACK = W_EN & !FULL and R_ACK = R_EN & !EMPTY from registered flags only, with no combinational path from R_EN to W_ACK or from W_EN to R_ACK.
REQ-008 On each rising edge with W_ACK high, the block SHALL increment W_PTR by 1 modulo 2^PTR_WIDTH.
REQ-009 On each rising edge with R_ACK high, the block SHALL increment R_PTR by 1 modulo 2^PTR_WIDTH.
REQ-010 The FIFO SHALL be first-word-fall-through: read data is valid whenever EMPTY is low, and R_ACK consumes the current word and advances to the next one in the same cycle.
REQ-011 COUNT SHALL be registered and updated as follows: +1 on W_ACK only, -1 on R_ACK only, unchanged on both or neither.
REQ-012 COUNT SHALL always equal W_PTR - R_PTR modulo 2^PTR_WIDTH.
REQ-013 FULL, EMPTY, ALMOST_FULL and ALMOST_EMPTY SHALL be registered and computed from the next COUNT, so each flag is valid in the same cycle that COUNT takes its new value.
REQ-014 FULL SHALL be asserted exactly when the pointer MSBs differ and the low bits are equal; EMPTY SHALL be asserted exactly when the pointers are equal.
REQ-015 When W_EN and R_EN are both high while FULL: the read SHALL be accepted, the write rejected, and OVERFLOW set; the cycle after, COUNT=DEPTH-1 and FULL=0.
REQ-016 When W_EN and R_EN are both high while EMPTY: the write SHALL be accepted, the read rejected, and UNDERFLOW set; the cycle after, COUNT=1 and EMPTY=0.
REQ-017 When both requests are accepted, the pointers SHALL advance, COUNT and all flags SHALL hold, and this SHALL sustain one transfer per cycle at any occupancy 1..DEPTH-1.
REQ-018 OVERFLOW SHALL be set on W_EN & FULL and UNDERFLOW on R_EN & EMPTY; both SHALL hold until CLR_ERR or reset.
REQ-019 If CLR_ERR coincides with a new error event, the set SHALL win.
REQ-020 Rejected requests SHALL NOT change pointers, COUNT or the almost flags.
REQ-021 Pointer wrap-around SHALL be seamless: after 2^PTR_WIDTH accepted writes W_PTR returns to 0 with no effect on the flags.

Reset
REQ-022 While NRST is low, the block SHALL immediately and asynchronously force W_PTR=0, R_PTR=0, COUNT=0, EMPTY=1, FULL=0, ALMOST_EMPTY=1, ALMOST_FULL=0, OVERFLOW=0 and UNDERFLOW=0.
REQ-023 The block SHALL release from reset synchronously, and the first request SHALL be honoured on the first rising edge with NRST high.
REQ-024 Reset asserted mid-operation SHALL discard all contents; the storage array itself is not cleared but its contents are unreachable.

Verification
REQ-025 Fill test: with DEPTH=16, after reset write 16 words (0x00..0x0F) -> ALMOST_FULL rises when COUNT=14 and FULL rises when COUNT=16; a 17th write gives W_ACK=0, OVERFLOW=1 and W_PTR=0x10.
REQ-026 Drain test: from full, read 16 words -> data 0x00..0x0F in order, EMPTY after the 16th read, ALMOST_EMPTY when COUNT<=2; an extra read gives R_ACK=0 and UNDERFLOW=1.
REQ-027 Streaming test: hold COUNT=8 with simultaneous W_EN/R_EN for 40 cycles -> COUNT stays 8, flags stay constant, both pointers wrap past 0x1F to 0x00, and the data order is preserved.
REQ-028 Boundary test: simultaneous W_EN/R_EN at FULL -> COUNT=15, OVERFLOW=1; simultaneous W_EN/R_EN at EMPTY -> COUNT=1, UNDERFLOW=1; CLR_ERR clears both next cycle.
REQ-029 Reset test: assert NRST low at COUNT=5, mid-clock-period -> all outputs take their reset values before the next edge; normal writes resume after release.
REQ-030 Random test: random W_EN/R_EN for 10k cycles against a scoreboard -> no data loss or reorder, and COUNT==W_PTR-R_PTR holds every cycle.
